// File: rtl/spi_master_if.sv
// Host/slave-facing signal bundle of the SPI master.
// The master modport is the controller's view; the slave modport is the view of whatever drives it.
interface spi_master_if #(
  parameter int unsigned NB_BITS = 32
);
  logic               i_start;
  logic [NB_BITS-1:0] i_data;
  logic               i_MISO;
  logic               o_SCLK;
  logic               o_MOSI;
  logic               o_cs;
  logic [NB_BITS-1:0] o_data;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_data, i_MISO,
    output o_SCLK, o_MOSI, o_cs, o_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_data, i_MISO,
    input  o_SCLK, o_MOSI, o_cs, o_data, o_busy, o_done
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex NB_BITS word per accepted i_start, MSB first.
// Chip select is active-high; every output is registered.
module spi_master #(
  parameter int unsigned NB_BITS = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  spi_master_if.master bus
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(NB_BITS) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NB_BITS-1:0] tx_q, tx_d;
  logic [NB_BITS-1:0] rx_q, rx_d;
  logic [NB_BITS-1:0] data_q, data_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_last_c;

  assign div_last_c = (div_q == CNT_W'(CLK_DIV - 1));

  assign bus.o_SCLK = sclk_q;
  assign bus.o_MOSI = mosi_q;
  assign bus.o_cs   = cs_q;
  assign bus.o_data = data_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; outputs appear one cycle after the state that requests them,
  // so the o_done cycle is already IDLE and can accept the next i_start.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = SETUP;
          tx_d    = bus.i_data;
          mosi_d  = bus.i_data[NB_BITS-1];
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (div_last_c) begin
          state_d = TRANSFER;
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[NB_BITS-2:0], bus.i_MISO};
          bit_d   = bit_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      TRANSFER: begin
        if (div_last_c) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[NB_BITS-2:0], bus.i_MISO};
            bit_d  = bit_q + 1'b1;
          end else if (bit_q == BIT_W'(NB_BITS)) begin
            sclk_d  = 1'b0;
            state_d = HOLD;
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[NB_BITS-2:0], 1'b0};
            mosi_d = tx_q[NB_BITS-2];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        // One cycle shorter than CLK_DIV here: DONE keeps cs high for the last visible hold cycle.
        if (div_q == CNT_W'(CLK_DIV - 2)) begin
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        data_d  = rx_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
